// File: rtl/fetch_redirect_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : fetch_redirect_ctrl_if
// Brief  : Redirect/prediction inputs and fetch-PC outputs of the IF0 PC mux.
// Rev    : 1.0
// ============================================================================
interface fetch_redirect_ctrl_if;
    logic        flush;
    logic        pause;
    logic [31:0] npc;
    logic        be_valid;
    logic [31:0] be_pc;
    logic        be_ready;
    logic        if3_redirect;
    logic [31:0] if3_pc;
    logic        nlp0_valid;
    logic        nlp0_taken;
    logic [31:0] nlp0_target;
    logic        nlp1_valid;
    logic        nlp1_taken;
    logic [31:0] nlp1_target;
    logic [31:0] pc;
    logic        only_get_ds;
    logic [2:0]  redir_src;
    logic [15:0] redir_cnt;

    // Pipeline/backend side
    modport master (
        output flush, pause, npc, be_valid, be_pc, if3_redirect, if3_pc,
               nlp0_valid, nlp0_taken, nlp0_target,
               nlp1_valid, nlp1_taken, nlp1_target,
        input  be_ready, pc, only_get_ds, redir_src, redir_cnt
    );

    // Fetch-redirect controller side
    modport slave (
        input  flush, pause, npc, be_valid, be_pc, if3_redirect, if3_pc,
               nlp0_valid, nlp0_taken, nlp0_target,
               nlp1_valid, nlp1_taken, nlp1_target,
        output be_ready, pc, only_get_ds, redir_src, redir_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module : fetch_redirect_ctrl
// Brief  : Selects the next fetch PC from backend/IF3/delay-slot/NLP sources.
// Rev    : 1.0
// ============================================================================
module fetch_redirect_ctrl (
    input  logic                        clk,
    input  logic                        rst,
    fetch_redirect_ctrl_if.slave        bus
);
    typedef enum logic [1:0] {
        ST_SEQ     = 2'd0,
        ST_DS_WAIT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    localparam logic [2:0] SRC_NPC  = 3'd0;
    localparam logic [2:0] SRC_BE   = 3'd1;
    localparam logic [2:0] SRC_IF3  = 3'd2;
    localparam logic [2:0] SRC_DS   = 3'd3;
    localparam logic [2:0] SRC_NLP0 = 3'd4;
    localparam logic [2:0] SRC_NLP1 = 3'd5;
    localparam logic [2:0] SRC_REL  = 3'd6;
    localparam logic [2:0] SRC_RST  = 3'd7;
    localparam logic       PEND_IF3 = 1'b0;
    localparam logic       PEND_BE  = 1'b1;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ds_addr_q, ds_addr_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        pend_src_q, pend_src_d;
    logic [2:0]  src_q, src_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ds_q;
    logic        cnt_inc;
    logic        be_ready_w;
    logic        be_acc;
    logic        if3_acc;
    logic        hold_be;

    // A captured backend target must not be lost while the pipe is paused.
    assign hold_be    = (state_q == ST_HOLD) && (pend_src_q == PEND_BE);
    assign be_ready_w = !(hold_be && bus.pause);
    assign be_acc     = bus.be_valid && be_ready_w;
    assign if3_acc    = bus.if3_redirect && !hold_be;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ds_addr_d  = ds_addr_q;
        pend_pc_d  = pend_pc_q;
        pend_src_d = pend_src_q;
        src_d      = src_q;
        cnt_inc    = 1'b0;
        if (bus.flush) begin
            state_d    = ST_SEQ;
            pc_d       = 32'h0;
            ds_addr_d  = 32'h0;
            pend_pc_d  = 32'h0;
            pend_src_d = PEND_IF3;
            src_d      = SRC_RST;
        end else if (bus.pause) begin
            if (be_acc) begin
                state_d    = ST_HOLD;
                pend_pc_d  = bus.be_pc;
                pend_src_d = PEND_BE;
            end else if (if3_acc) begin
                state_d    = ST_HOLD;
                pend_pc_d  = bus.if3_pc;
                pend_src_d = PEND_IF3;
            end
        end else begin
            state_d = ST_SEQ;
            cnt_inc = 1'b1;
            if (be_acc) begin
                pc_d  = bus.be_pc;
                src_d = SRC_BE;
            end else if (if3_acc) begin
                pc_d  = bus.if3_pc;
                src_d = SRC_IF3;
            end else if (state_q == ST_DS_WAIT) begin
                pc_d  = ds_addr_q;
                src_d = SRC_DS;
            end else if (state_q == ST_HOLD) begin
                pc_d  = pend_pc_q;
                src_d = SRC_REL;
            end else if (bus.nlp0_valid && bus.nlp0_taken) begin
                pc_d  = bus.nlp0_target;
                src_d = SRC_NLP0;
            end else if (bus.nlp1_valid && bus.nlp1_taken) begin
                // Fetch the delay slot first, then the predicted target.
                pc_d      = bus.npc;
                ds_addr_d = bus.nlp1_target;
                state_d   = ST_DS_WAIT;
                src_d     = SRC_NLP1;
            end else begin
                pc_d    = bus.npc;
                src_d   = SRC_NPC;
                cnt_inc = 1'b0;
            end
        end
        cnt_d = (cnt_inc && (cnt_q != CNT_MAX)) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_SEQ;
            pc_q       <= 32'h0;
            ds_addr_q  <= 32'h0;
            pend_pc_q  <= 32'h0;
            pend_src_q <= PEND_IF3;
            src_q      <= SRC_RST;
            cnt_q      <= 16'h0;
            ds_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ds_addr_q  <= ds_addr_d;
            pend_pc_q  <= pend_pc_d;
            pend_src_q <= pend_src_d;
            src_q      <= src_d;
            cnt_q      <= cnt_d;
            ds_q       <= (state_d == ST_DS_WAIT);
        end
    end

    assign bus.be_ready    = be_ready_w;
    assign bus.pc          = pc_q;
    assign bus.only_get_ds = ds_q;
    assign bus.redir_src   = src_q;
    assign bus.redir_cnt   = cnt_q;
endmodule
`default_nettype wire
